// File: rtl/rst_controller_mc.sv
// Multi-channel software reset generator on an Avalon-MM register bus.
// Each rst_out bit is a level-held bit OR a self-timed, retriggerable pulse.
module rst_controller_mc #(
  parameter int unsigned       NUM_CH        = 4,
  parameter int unsigned       CNT_W         = 16,
  parameter int unsigned       DEFAULT_PULSE = 100,
  parameter logic [NUM_CH-1:0] RST_INIT      = {NUM_CH{1'b1}}
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy
);

  localparam logic [1:0]       AddrLevel  = 2'd0;
  localparam logic [1:0]       AddrPulse  = 2'd1;
  localparam logic [1:0]       AddrLen    = 2'd2;
  localparam logic [1:0]       AddrStatus = 2'd3;
  localparam logic [CNT_W-1:0] PlenRst    = CNT_W'(DEFAULT_PULSE);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  typedef enum logic {StIdle, StPulse} ch_state_e;

  // Assertion is asynchronous; deassertion is retimed through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  ch_state_e         state_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [NUM_CH-1:0] level_q, pulse_q, done_q, rst_out_q;
  logic [CNT_W-1:0]  plen_q;
  logic [31:0]       readdata_q;

  logic              wr_level, wr_pulse, wr_len, wr_status;
  logic [NUM_CH-1:0] wdata_ch, pulse_start, cnt_last, pulse_d, level_d, done_d, done_set;
  logic [CNT_W-1:0]  plen_eff;
  logic [31:0]       rdata;
  logic              unused_wdata;

  assign unused_wdata = ^writedata;
  assign wdata_ch     = writedata[NUM_CH-1:0];
  assign wr_level     = write && (address == AddrLevel);
  assign wr_pulse     = write && (address == AddrPulse);
  assign wr_len       = write && (address == AddrLen);
  assign wr_status    = write && (address == AddrStatus);
  assign pulse_start  = wr_pulse ? wdata_ch : '0;
  assign plen_eff     = (plen_q == '0) ? CntOne : plen_q;
  assign level_d      = wr_level ? wdata_ch : level_q;

  always_comb begin
    cnt_last = '0;
    pulse_d  = '0;
    done_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_last[i] = (state_q[i] == StPulse) && (cnt_q[i] == CntOne);
      pulse_d[i]  = pulse_start[i] | ((state_q[i] == StPulse) & ~cnt_last[i]);
      // A retrigger on the final cycle aborts the pulse, so no completion.
      done_set[i] = cnt_last[i] & ~pulse_start[i];
    end
    done_d = (done_q & ~(wr_status ? wdata_ch : '0)) | done_set;
  end

  // Register reads return pre-write state when read and write coincide.
  always_comb begin
    rdata = '0;
    unique case (address)
      AddrLevel:  rdata[NUM_CH-1:0] = level_q;
      AddrPulse:  rdata[NUM_CH-1:0] = pulse_q;
      AddrLen:    rdata[CNT_W-1:0]  = plen_q;
      AddrStatus: begin
        rdata[NUM_CH-1:0] = done_q;
        rdata[31:24]      = 8'(NUM_CH);
      end
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      level_q    <= RST_INIT;
      pulse_q    <= '0;
      done_q     <= '0;
      rst_out_q  <= RST_INIT;
      plen_q     <= PlenRst;
      readdata_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        unique case (state_q[i])
          StIdle: begin
            if (pulse_start[i]) begin
              state_q[i] <= StPulse;
              cnt_q[i]   <= plen_eff;
            end
          end
          StPulse: begin
            if (pulse_start[i]) begin
              cnt_q[i] <= plen_eff;
            end else begin
              cnt_q[i] <= cnt_q[i] - CntOne;
              if (cnt_last[i]) state_q[i] <= StIdle;
            end
          end
          default: state_q[i] <= StIdle;
        endcase
      end
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      done_q    <= done_d;
      rst_out_q <= level_d | pulse_d;
      if (wr_len) plen_q <= writedata[CNT_W-1:0];
      if (read) readdata_q <= rdata;
    end
  end

  assign readdata = readdata_q;
  assign rst_out  = rst_out_q;
  assign busy     = |pulse_q;

endmodule

// File: tb/tb_rst_controller_mc.sv
// Self-checking bench for rst_controller_mc: register vector table plus
// hand-written pulse, retrigger, collision and async-reset sequences.
module tb_rst_controller_mc;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  rst_out;
  logic        busy;

  rst_controller_mc #(
    .NUM_CH(4),
    .CNT_W(16),
    .DEFAULT_PULSE(100),
    .RST_INIT(4'b1111)
  ) dut (
    .clk_sys(clk_sys),
    .rst_n(rst_n),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .rst_out(rst_out),
    .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [1:0]  addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [3:0]  exp_rst;
  } vec_t;

  vec_t        vecs [14];
  logic [31:0] sb [$];
  logic        rd_d = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          hi, bz, tot;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Scoreboard: expected read data is queued at issue and popped one cycle later.
  always @(posedge clk_sys) rd_d <= read;
  always @(negedge clk_sys) begin
    if (rd_d) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow: got read with no expected value, expected queued entry");
      end else begin
        check("readdata", readdata, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic bus(input logic [1:0] a, input logic w, input logic r,
                     input logic [31:0] wd, input logic [31:0] exp);
    address   = a;
    write     = w;
    read      = r;
    writedata = wd;
    if (r) sb.push_back(exp);
    @(negedge clk_sys);
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic count_high(input int ch, input int n, output int h, output int b);
    h = 0;
    b = 0;
    for (int k = 0; k < n; k++) begin
      h += int'(rst_out[ch]);
      b += int'(busy);
      @(negedge clk_sys);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{2'd2, 1'b0, 1'b1, 32'h0,         32'd100,       4'hF};
    vecs[1]  = '{2'd3, 1'b0, 1'b1, 32'h0,         32'h0400_0000, 4'hF};
    vecs[2]  = '{2'd0, 1'b0, 1'b1, 32'h0,         32'h0000_000F, 4'hF};
    vecs[3]  = '{2'd1, 1'b0, 1'b1, 32'h0,         32'h0,         4'hF};
    vecs[4]  = '{2'd0, 1'b1, 1'b0, 32'h5,         32'h0,         4'h5};
    vecs[5]  = '{2'd0, 1'b0, 1'b1, 32'h0,         32'h5,         4'h5};
    vecs[6]  = '{2'd0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,         4'h0};
    vecs[7]  = '{2'd0, 1'b1, 1'b1, 32'h3,         32'h0,         4'h3};
    vecs[8]  = '{2'd0, 1'b0, 1'b1, 32'h0,         32'h3,         4'h3};
    vecs[9]  = '{2'd0, 1'b1, 1'b0, 32'h0,         32'h0,         4'h0};
    vecs[10] = '{2'd2, 1'b1, 1'b0, 32'hABCD_0007, 32'h0,         4'h0};
    vecs[11] = '{2'd2, 1'b0, 1'b1, 32'h0,         32'h7,         4'h0};
    vecs[12] = '{2'd2, 1'b1, 1'b0, 32'h3,         32'h0,         4'h0};
    vecs[13] = '{2'd2, 1'b0, 1'b1, 32'h0,         32'h3,         4'h0};

    rst_n = 1'b0;
    address = 2'd0;
    read = 1'b0;
    write = 1'b0;
    writedata = 32'h0;
    repeat (3) tick();
    check("reset_rst_out", 32'(rst_out), 32'hF);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_readdata", readdata, 32'h0);
    rst_n = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 14; i++) begin
      bus(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_rst_out", i), 32'(rst_out), 32'(vecs[i].exp_rst));
    end

    // Pulse width 3 on ch1, then W1C of done.
    bus(2'd1, 1'b1, 1'b0, 32'h2, 32'h0);
    count_high(1, 10, hi, bz);
    check("pulse3_width", 32'(hi), 32'd3);
    check("pulse3_busy", 32'(bz), 32'd3);
    bus(2'd3, 1'b0, 1'b1, 32'h0, 32'h0400_0002);
    bus(2'd3, 1'b1, 1'b0, 32'h2, 32'h0);
    bus(2'd3, 1'b0, 1'b1, 32'h0, 32'h0400_0000);

    // plen = 0 behaves as 1.
    bus(2'd2, 1'b1, 1'b0, 32'h0, 32'h0);
    bus(2'd1, 1'b1, 1'b0, 32'h1, 32'h0);
    count_high(0, 6, hi, bz);
    check("plen0_width", 32'(hi), 32'd1);
    bus(2'd3, 1'b0, 1'b1, 32'h0, 32'h0400_0001);
    bus(2'd3, 1'b1, 1'b0, 32'hF, 32'h0);

    // Retrigger ch2 three cycles into a 5-cycle pulse: 8 cycles total.
    bus(2'd2, 1'b1, 1'b0, 32'h5, 32'h0);
    bus(2'd1, 1'b1, 1'b0, 32'h4, 32'h0);
    tot = int'(rst_out[2]);
    tick();
    tot += int'(rst_out[2]);
    tick();
    tot += int'(rst_out[2]);
    bus(2'd1, 1'b1, 1'b0, 32'h4, 32'h0);
    count_high(2, 12, hi, bz);
    check("retrigger_width", 32'(tot + hi), 32'd8);
    bus(2'd3, 1'b0, 1'b1, 32'h0, 32'h0400_0004);
    bus(2'd3, 1'b1, 1'b0, 32'hF, 32'h0);

    // W1C of done[3] on the completion cycle: set wins.
    bus(2'd2, 1'b1, 1'b0, 32'h2, 32'h0);
    bus(2'd1, 1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    bus(2'd3, 1'b1, 1'b0, 32'h8, 32'h0);
    bus(2'd3, 1'b0, 1'b1, 32'h0, 32'h0400_0008);
    bus(2'd3, 1'b1, 1'b0, 32'h8, 32'h0);
    bus(2'd3, 1'b0, 1'b1, 32'h0, 32'h0400_0000);

    // LEVEL write mid-pulse keeps ch0 in reset after the pulse ends.
    bus(2'd2, 1'b1, 1'b0, 32'h4, 32'h0);
    bus(2'd1, 1'b1, 1'b0, 32'h1, 32'h0);
    tick();
    bus(2'd0, 1'b1, 1'b0, 32'h1, 32'h0);
    repeat (8) tick();
    check("level_mid_rst_out", 32'(rst_out), 32'h1);
    check("level_mid_busy", 32'(busy), 32'h0);
    bus(2'd1, 1'b0, 1'b1, 32'h0, 32'h0);
    bus(2'd3, 1'b0, 1'b1, 32'h0, 32'h0400_0001);
    bus(2'd0, 1'b1, 1'b0, 32'h0, 32'h0);
    check("level_clear_rst_out", 32'(rst_out), 32'h0);
    bus(2'd3, 1'b1, 1'b0, 32'hF, 32'h0);

    // Async reset in the middle of a 10-cycle ch1 pulse.
    bus(2'd2, 1'b1, 1'b0, 32'd10, 32'h0);
    bus(2'd1, 1'b1, 1'b0, 32'h2, 32'h0);
    repeat (3) tick();
    check("async_pre_busy", 32'(busy), 32'h1);
    check("async_pre_rst_out", 32'(rst_out), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(rst_out), 32'hF);
    check("async_busy", 32'(busy), 32'h0);
    check("async_readdata", readdata, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    bus(2'd3, 1'b0, 1'b1, 32'h0, 32'h0400_0000);
    bus(2'd1, 1'b0, 1'b1, 32'h0, 32'h0);
    bus(2'd2, 1'b0, 1'b1, 32'h0, 32'd100);
    repeat (12) tick();
    check("post_reset_busy", 32'(busy), 32'h0);
    check("post_reset_rst_out", 32'(rst_out), 32'hF);
    tick();
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_controller_mc.md
Name: rst_controller_mc

Overview:
- Multi-channel, software-controlled reset generator on the clk_sys Avalon-MM register bus.
- Drives NUM_CH independent reset outputs (CPU core, peripherals, DMA, ...). Each output is the OR of a level-held bit and a self-timed pulse generator.
- Pulse width is programmable; completion is reported via sticky write-1-to-clear flags.

Parameters:
- NUM_CH, 4, number of reset channels (1..16)
- CNT_W, 16, width of the pulse-length register and per-channel down-counters
- DEFAULT_PULSE, 100, pulse length in clk_sys cycles after reset (must fit in CNT_W)
- RST_INIT, {NUM_CH{1'b1}}, level-register value after reset (1 = channel held in reset)

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- address  in  2  word address of register
- read  in  1  read strobe, one cycle
- write  in  1  write strobe, one cycle
- writedata  in  32  write data
- readdata  out  32  registered read data
- rst_out  out  NUM_CH  per-channel reset, active-high
- busy  out  1  OR of all pulse_active bits

Behaviour:
- Register map. Bits at or above NUM_CH are ignored on write and read as 0.
  - 0 LEVEL: write sets level[NUM_CH-1:0]. Read returns level.
  - 1 PULSE: write with bit i = 1 starts a pulse on channel i; bits = 0 have no effect. Read returns pulse_active mask.
  - 2 PULSE_LEN: write loads plen = writedata[CNT_W-1:0]. Read returns plen zero-extended.
  - 3 STATUS: read returns done mask in [NUM_CH-1:0] and NUM_CH in [31:24]. Write of 1 in bit i clears done[i].
- Async reset (rst_n = 0), effective immediately:
  - level = RST_INIT, so rst_out = RST_INIT.
  - pulse_active = 0, counters = 0, done = 0, busy = 0.
  - plen = DEFAULT_PULSE, readdata = 0.
- Reset deassertion: all state leaves reset on a clk_sys edge. An internal 2-flop synchroniser on rst_n removes deassertion metastability; assertion stays asynchronous.
- rst_out[i] = level[i] | pulse_active[i]. It is registered and changes on the clock edge after the write.
- Per-channel FSM, states IDLE and PULSE:
  - IDLE -> PULSE on a PULSE write with bit i = 1. Counter loads max(plen, 1); pulse_active[i] = 1 from the next cycle.
  - In PULSE, the counter decrements every cycle. When it is 1, the next edge gives counter = 0, pulse_active = 0, done[i] = 1, state IDLE.
  - Result: rst_out is high for exactly max(plen, 1) cycles (when level[i] = 0).
  - PULSE write to an already-pulsing channel reloads the counter with max(plen, 1) (retrigger/extend); done is not set for the aborted pulse.
  - plen = 0 is treated as 1.
- A PULSE_LEN write while pulses run affects only pulses started afterwards.
- A LEVEL write during a pulse does not affect the pulse counter. rst_out stays high while either source is active.
- Same-cycle done set and STATUS W1C of that bit: set wins, done = 1.
- Read latency 1: readdata is valid the cycle after the read strobe. readdata holds its value when read = 0.
- Simultaneous read and write to the same address: readdata returns the pre-write value.
- No waitrequest. Every access completes in one cycle.

Test Plan:
- Reset: hold rst_n = 0, then release. rst_out = 4'b1111, busy = 0. Read addr 2 gives 100; read addr 3 gives 32'h04000000.
- Level control: write addr0 = 4'b0101. From next cycle rst_out = 4'b0101. Read addr0 gives 5.
- Pulse width: level = 0, plen = 3, write addr1 = 4'b0010. rst_out[1] is high exactly 3 cycles, busy is high for the same 3 cycles. Then done = 4'b0010; W1C write addr3 = 2 clears it to 0.
- plen = 0 and retrigger: plen = 0 plus pulse on ch0 gives 1 cycle high. With plen = 5, pulse ch2, then re-pulse ch2 after 3 cycles: 8 cycles high total, done[2] set once at the end.
- Simultaneous events: W1C of done[3] on the same cycle ch3 completes gives done[3] = 1. LEVEL write of ch0 = 1 mid-pulse keeps rst_out[0] high after the pulse ends.
- Async reset mid-pulse: drop rst_n while a ch1 pulse of 10 cycles is running. rst_out returns to RST_INIT immediately without waiting for a clock edge, counter = 0, done = 0.
